// File: rtl/sound_event_sequencer_pkg.sv
// Shared event codes, FSM states and note table for the sound event sequencer.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package snd_pkg;

   // Game event codes as they are stored in the event FIFO.
   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_GOOD = 2'd1,
      EV_BAD  = 2'd2,
      EV_MOVE = 2'd3
   } event_t;

   // Note player states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Oscillator frequency codes for each playable event.
   localparam logic [7:0] FREQ_GOOD = 8'd89;
   localparam logic [7:0] FREQ_BAD  = 8'd126;
   localparam logic [7:0] FREQ_MOVE = 8'd149;

   // Number of distinct playable event kinds.
   localparam int MODE_TYPES = 3;

   function automatic logic [7:0] note_freq(input event_t ev);
      case (ev)
         EV_GOOD: note_freq = FREQ_GOOD;
         EV_BAD:  note_freq = FREQ_BAD;
         EV_MOVE: note_freq = FREQ_MOVE;
         default: note_freq = 8'd0;
      endcase
   endfunction

   // Note length in clock cycles; a move note is half the base length but
   // never shorter than one cycle.
   function automatic int note_len(input event_t ev, input int note_ticks);
      case (ev)
         EV_GOOD: note_len = note_ticks;
         EV_BAD:  note_len = 2 * note_ticks;
         EV_MOVE: note_len = (note_ticks / 2 < 1) ? 1 : note_ticks / 2;
         default: note_len = 0;
      endcase
   endfunction

endpackage

// File: rtl/sound_event_sequencer_if.sv
// Event-in / tone-out bundle between the game logic, the sequencer and the oscillator.
// Latency: none (wires only).
// Backpressure: none; the sequencer reports overflow through drop instead of stalling.
// Ports: en, good_coll, bad_coll, move (events in); freq, play_sound, busy, drop,
//        queue_count (sequencer status/tone out).
interface sound_event_sequencer_if #(
   parameter int DEPTH = 4
) ();
   localparam int QW = $clog2(DEPTH + 1);

   logic          en;
   logic          good_coll;
   logic          bad_coll;
   logic          move;
   logic [7:0]    freq;
   logic          play_sound;
   logic          busy;
   logic          drop;
   logic [QW-1:0] queue_count;

   // Event source / tone consumer side.
   modport master (
      output en, good_coll, bad_coll, move,
      input  freq, play_sound, busy, drop, queue_count
   );

   // Sequencer side.
   modport slave (
      input  en, good_coll, bad_coll, move,
      output freq, play_sound, busy, drop, queue_count
   );
endinterface

// File: rtl/sound_event_sequencer_event_fifo.sv
// Small synchronous FIFO of 2-bit event codes with flush and occupancy count.
// Latency: written on the push edge, head visible combinationally on dout the cycle after.
// Backpressure: push on full and pop on empty are ignored; caller reports drops.
// Ports: clk, rst, push, pop, flush, din -> dout, full, empty, count.
module event_fifo
   import snd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  event_t                       din,
   output event_t                       dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   event_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_en;
   logic          rd_en;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap around on natural overflow.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   end

   // Storage needs no reset: entries are only read between valid pointers.
   always_ff @(posedge clk) begin
      if (wr_en && !rst && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sound_event_sequencer.sv
// Queued, timed note player feeding the tone oscillator from game-event pulses.
// Latency: pulse at edge t is queued at t; if idle and empty the note starts after edge t+1.
// Backpressure: none upstream; excess or coincident lower-priority pulses pulse drop.
// Ports: clk, rst (sync, active-high); bus.slave carries en, good_coll, bad_coll, move in
//        and freq, play_sound, busy, drop, queue_count out (all outputs registered).
module sound_event_sequencer
   import snd_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int NOTE_TICKS = 25,
   parameter int GAP_TICKS  = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   sound_event_sequencer_if.slave  bus
);
   localparam int QW = $clog2(DEPTH + 1);
   // Sized for the longest note; widened only if the gap were ever longer.
   localparam int CMAX = (2 * NOTE_TICKS > GAP_TICKS) ? 2 * NOTE_TICKS : GAP_TICKS;
   localparam int CW   = $clog2(CMAX + 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0]    freq_q, freq_n;
   logic          play_q, play_n;
   logic          busy_q, busy_n;
   logic          drop_q, drop_n;

   event_t        sel_ev;
   logic          lower_hit;
   logic          push_req;
   logic          pop;
   logic          load;
   event_t        head;
   logic          full;
   logic          empty;
   logic [QW-1:0] occ;
   logic [QW-1:0] occ_n;

   // Priority select: bad > good > move. Any lower pulse that loses is a drop.
   always_comb begin
      sel_ev = EV_NONE;
      if (bus.bad_coll)       sel_ev = EV_BAD;
      else if (bus.good_coll) sel_ev = EV_GOOD;
      else if (bus.move)      sel_ev = EV_MOVE;
   end

   assign lower_hit = (bus.bad_coll && (bus.good_coll || bus.move)) ||
                      (bus.good_coll && bus.move);
   assign push_req  = bus.en && (sel_ev != EV_NONE);

   event_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop),
      .flush (!bus.en),
      .din   (sel_ev),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (occ)
   );

   // Next-state / output logic. A note load happens from IDLE or at the end
   // of a gap, so back-to-back notes never pass through IDLE.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      freq_n  = freq_q;
      play_n  = play_q;
      load    = 1'b0;
      pop     = 1'b0;

      if (!bus.en) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
         freq_n  = '0;
         play_n  = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               load = !empty;
            end
            ST_PLAY: begin
               if (cnt == CW'(1)) begin
                  state_n = ST_GAP;
                  cnt_n   = CW'(GAP_TICKS);
                  freq_n  = '0;
                  play_n  = 1'b0;
               end else begin
                  cnt_n = cnt - CW'(1);
               end
            end
            ST_GAP: begin
               if (cnt == CW'(1)) begin
                  if (!empty) begin
                     load = 1'b1;
                  end else begin
                     state_n = ST_IDLE;
                     cnt_n   = '0;
                  end
               end else begin
                  cnt_n = cnt - CW'(1);
               end
            end
            default: begin
               state_n = ST_IDLE;
               cnt_n   = '0;
               freq_n  = '0;
               play_n  = 1'b0;
            end
         endcase

         if (load) begin
            pop     = 1'b1;
            state_n = ST_PLAY;
            cnt_n   = CW'(note_len(head, NOTE_TICKS));
            freq_n  = note_freq(head);
            play_n  = 1'b1;
         end
      end
   end

   // Mirror of the FIFO's next occupancy so busy can be registered in step
   // with queue_count. Full is judged on pre-pop occupancy.
   always_comb begin
      if (!bus.en) occ_n = '0;
      else         occ_n = occ + QW'(push_req && !full) - QW'(pop);
   end

   assign busy_n = (state_n != ST_IDLE) || (occ_n != '0);
   assign drop_n = bus.en && (lower_hit || (push_req && full));

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         freq_q <= '0;
         play_q <= 1'b0;
         busy_q <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         freq_q <= freq_n;
         play_q <= play_n;
         busy_q <= busy_n;
         drop_q <= drop_n;
      end
   end

   assign bus.freq        = freq_q;
   assign bus.play_sound  = play_q;
   assign bus.busy        = busy_q;
   assign bus.drop        = drop_q;
   assign bus.queue_count = occ;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Scoreboarded random/directed bench for the sound event sequencer.
// The reference model tracks pending events in a queue and note timing as
// absolute start/end cycle numbers, pushing one expected output set per edge.
module tb_sound_event_sequencer;
   import snd_pkg::*;

   localparam int DEPTH = 4;
   localparam int NT    = 4;
   localparam int GT    = 2;

   typedef struct {
      int freq;
      bit play;
      bit busy;
      bit drop;
      int qc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sound_event_sequencer_if #(.DEPTH(DEPTH)) bus ();

   sound_event_sequencer #(
      .DEPTH      (DEPTH),
      .NOTE_TICKS (NT),
      .GAP_TICKS  (GT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sbq[$];
   int   vectors    = 0;
   int   miscompares = 0;

   // Reference model state.
   int mq[$];
   bit active   = 0;
   int n        = 0;
   int note_end = 0;
   int gap_end  = 0;
   int cur_freq = 0;

   // Event codes in the model: 1 good, 2 bad, 3 move.
   function automatic int freq_of(input int ev);
      case (ev)
         1: freq_of = 89;
         2: freq_of = 126;
         3: freq_of = 149;
         default: freq_of = 0;
      endcase
   endfunction

   function automatic int len_of(input int ev);
      case (ev)
         1: len_of = NT;
         2: len_of = 2 * NT;
         3: len_of = (NT / 2 < 1) ? 1 : NT / 2;
         default: len_of = 0;
      endcase
   endfunction

   task automatic step(input bit r, input bit e, input bit g, input bit b, input bit m);
      exp_t x;
      bit   start;
      bit   hit_lo;
      bit   fdrop;
      int   sel;
      int   pre;
      int   ev;
      rst           = r;
      bus.en        = e;
      bus.good_coll = g;
      bus.bad_coll  = b;
      bus.move      = m;
      @(posedge clk);
      n++;
      if (r || !e) begin
         mq.delete();
         active = 0;
         x.freq = 0; x.play = 0; x.busy = 0; x.drop = 0; x.qc = 0;
      end else begin
         start = 0;
         if (active && n == gap_end) begin
            if (mq.size() > 0) start = 1;
            else active = 0;
         end else if (!active && mq.size() > 0) begin
            start = 1;
         end
         pre    = mq.size();
         sel    = b ? 2 : (g ? 1 : (m ? 3 : 0));
         hit_lo = (b && (g || m)) || (g && m);
         fdrop  = (sel != 0) && (pre == DEPTH);
         if (start) begin
            ev       = mq.pop_front();
            active   = 1;
            cur_freq = freq_of(ev);
            note_end = n + len_of(ev);
            gap_end  = note_end + GT;
         end
         if (sel != 0 && !fdrop) mq.push_back(sel);
         x.play = active && (n < note_end);
         x.freq = x.play ? cur_freq : 0;
         x.busy = active || (mq.size() > 0);
         x.drop = hit_lo || fdrop;
         x.qc   = mq.size();
      end
      sbq.push_back(x);
      #1;
   endtask

   task automatic idle(input int k);
      repeat (k) step(0, 1, 0, 0, 0);
   endtask

   // Monitor: every edge produces an output set; compare it away from the edge.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            x = sbq.pop_front();
            vectors++;
            if (bus.freq !== 8'(x.freq) || bus.play_sound !== x.play ||
                bus.busy !== x.busy || bus.drop !== x.drop ||
                bus.queue_count !== 3'(x.qc)) begin
               miscompares++;
               $display("FAIL outputs t=%0t: got freq=%0d play=%b busy=%b drop=%b qc=%0d, want freq=%0d play=%b busy=%b drop=%b qc=%0d",
                        $time, bus.freq, bus.play_sound, bus.busy, bus.drop, bus.queue_count,
                        x.freq, x.play, x.busy, x.drop, x.qc);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit e;
      // Reset and quiet idle.
      repeat (3) step(1, 1, 0, 0, 0);
      idle(6);

      // Single good note.
      step(0, 1, 1, 0, 0);
      idle(10);

      // Bad note, then move queued two edges later: back-to-back via gap.
      step(0, 1, 0, 1, 0);
      idle(1);
      step(0, 1, 0, 0, 1);
      idle(20);

      // Good and bad together: only bad queued, one drop.
      step(0, 1, 1, 1, 0);
      idle(14);

      // Six consecutive moves: one popped, four queued, one dropped.
      repeat (6) step(0, 1, 0, 0, 1);
      idle(40);

      // en drop mid-note with three queued; pulses ignored while off.
      step(0, 1, 0, 1, 0);
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 0, 1);
      step(0, 1, 1, 0, 0);
      idle(1);
      step(0, 0, 1, 1, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 1);
      idle(4);

      // Reset in the gap, then a normal note.
      step(0, 1, 1, 0, 0);
      idle(5);
      step(1, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      idle(12);

      // Random traffic with occasional en drops and resets.
      e = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 149) == 0) e = ~e;
         if (!e && $urandom_range(0, 9) == 0) e = 1;
         step(($urandom_range(0, 499) == 0), e,
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 5) == 0));
      end
      idle(30);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, want 0", sbq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
